ring_4_monitor: RTL and testbench

//  Downstream checker for the synchronous ring counter: samples its one-hot q bus and

---
 rtl/ring_4_monitor.sv | 244 ++++++++++++++++++++++++
 tb/tb_ring_4_monitor.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_4_monitor.sv
// ============================================================================
// ring_4_monitor
// ----------------------------------------------------------------------------
// Downstream checker for a synchronous one-hot ring counter. Each enabled
// cycle it samples the ring's q bus, confirms that q is one-hot and that it is
// exactly one rotation step ahead of the previous sample, and tracks a small
// ACQ -> LOCK -> FAULT state machine. It reports:
//   * the binary index of the hot bit (phase) and whether the last sample was
//     one-hot (phase_valid),
//   * lock status (locked),
//   * a one-cycle pulse each time a locked ring comes back to bit 0 (wrap),
//   * a free-running revolution counter (rev_count),
//   * a sticky fault flag (err) and a saturating fault counter (err_count).
// Every output is registered, so results appear one cycle after the sample.
//
// Configuration macro:
//   RING_MON_ERRCNT_EN  defined   -> err_count counts LOCK->FAULT transitions,
//                                    saturating at all-ones.
//                       undefined -> no counter logic; err_count is tied to 0.
//                                    err remains sticky in both builds.
//
// Parameters:
//   WIDTH     ring length (bits of q), >= 2
//   ROT_LEFT  1: expect q_next = {q[W-2:0], q[W-1]}; 0: rotate right
//   LOCK_CNT  consecutive legal steps needed to enter LOCK (>= 1)
//   REV_W     width of rev_count
//   ERR_W     width of err_count
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   en           in   sample enable; all state holds when low (wrap drops)
//   clear        in   synchronous clear of err / err_count / rev_count,
//                     independent of en, wins over a same-cycle set/increment
//   q            in   ring counter output being monitored
//   phase        out  index of the hot bit in the last one-hot sample
//   phase_valid  out  last sample was one-hot
//   locked       out  FSM is in LOCK
//   wrap         out  1-cycle pulse: locked ring returned to bit 0
//   rev_count    out  number of wrap pulses, modulo 2^REV_W
//   err          out  sticky fault flag
//   err_count    out  number of LOCK->FAULT transitions, saturating
// ============================================================================
module ring_4_monitor #(
    parameter int WIDTH    = 4,
    parameter int ROT_LEFT = 1,
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8,
    parameter int ERR_W    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         q,
    output logic [$clog2(WIDTH)-1:0] phase,
    output logic                     phase_valid,
    output logic                     locked,
    output logic                     wrap,
    output logic [REV_W-1:0]         rev_count,
    output logic                     err,
    output logic [ERR_W-1:0]         err_count
);

    localparam int PH_W   = $clog2(WIDTH);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        ST_ACQ   = 2'd0,
        ST_LOCK  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t            r_state;
    logic [GOOD_W-1:0] r_good_cnt;
    logic [WIDTH-1:0]  r_prev;
    logic              r_prev_valid;
    logic [PH_W-1:0]   r_phase;
    logic              r_phase_valid;
    logic              r_locked;
    logic              r_wrap;
    logic [REV_W-1:0]  r_rev_count;
    logic              r_err;

    // ------------------------------------------------------------------------
    // Sample decode
    // ------------------------------------------------------------------------
    logic              w_onehot;
    logic [WIDTH-1:0]  w_rot_prev;
    logic              w_step_ok;
    logic              w_legal;
    logic [PH_W-1:0]   w_index;
    logic              w_is_bit0;
    logic              w_lock_fault;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_onehot = (q != '0) && ((q & (q - WIDTH'(1))) == '0);

    // The value the ring must show next if it rotated legally from r_prev.
    assign w_rot_prev = (ROT_LEFT != 0) ? {r_prev[WIDTH-2:0], r_prev[WIDTH-1]}
                                        : {r_prev[0], r_prev[WIDTH-1:1]};

    // The very first sample after reset has nothing to compare against.
    assign w_step_ok = r_prev_valid && (q == w_rot_prev);
    assign w_legal   = w_onehot && w_step_ok;
    assign w_is_bit0 = (q == WIDTH'(1));

    // A fault is only counted on the LOCK -> FAULT transition.
    assign w_lock_fault = en && (r_state == ST_LOCK) && !w_legal;

    // NOTE: every signal written in always_comb gets a default at the top of
    // the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q[i]) begin
                w_index = i[PH_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sampling path, FSM and revolution / fault reporting
    // ------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments only, so every
    // register in this block sees the pre-edge value of every other one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_ACQ;
            r_good_cnt    <= '0;
            r_prev        <= '0;
            r_prev_valid  <= 1'b0;
            r_phase       <= '0;
            r_phase_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_wrap        <= 1'b0;
            r_rev_count   <= '0;
            r_err         <= 1'b0;
        end else begin
            if (en) begin
                r_prev        <= q;
                r_prev_valid  <= 1'b1;
                r_phase_valid <= w_onehot;
                if (w_onehot) begin
                    r_phase <= w_index;
                end
                r_wrap <= 1'b0;

                unique case (r_state)
                    ST_ACQ: begin
                        if (w_legal) begin
                            if (r_good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                                r_state    <= ST_LOCK;
                                r_locked   <= 1'b1;
                                r_good_cnt <= '0;
                            end else begin
                                r_good_cnt <= r_good_cnt + GOOD_W'(1);
                            end
                        end else begin
                            r_good_cnt <= '0;
                        end
                    end

                    ST_LOCK: begin
                        if (w_legal) begin
                            if (w_is_bit0) begin
                                r_wrap      <= 1'b1;
                                r_rev_count <= r_rev_count + REV_W'(1);
                            end
                        end else begin
                            r_state  <= ST_FAULT;
                            r_locked <= 1'b0;
                            r_err    <= 1'b1;
                        end
                    end

                    ST_FAULT: begin
                        // Any one-hot sample restarts acquisition; the step
                        // check resumes from this sample onwards.
                        if (w_onehot) begin
                            r_state    <= ST_ACQ;
                            r_good_cnt <= '0;
                        end
                    end

                    default: begin
                        r_state    <= ST_ACQ;
                        r_locked   <= 1'b0;
                        r_good_cnt <= '0;
                    end
                endcase
            end else begin
                r_wrap <= 1'b0;
            end

            // Placed after the sampling logic so that, being the last
            // assignment to these registers, clear beats a same-cycle set
            // or increment.
            if (clear) begin
                r_err       <= 1'b0;
                r_rev_count <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional fault counter
    // ------------------------------------------------------------------------
`ifdef RING_MON_ERRCNT_EN
    logic [ERR_W-1:0] r_err_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_count <= '0;
        end else if (clear) begin
            r_err_count <= '0;
        end else if (w_lock_fault && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign phase       = r_phase;
    assign phase_valid = r_phase_valid;
    assign locked      = r_locked;
    assign wrap        = r_wrap;
    assign rev_count   = r_rev_count;
    assign err         = r_err;

    // Only consumed by the optional counter.
    logic w_unused;
    assign w_unused = w_lock_fault;

endmodule

// File: tb/tb_ring_4_monitor.sv
// ============================================================================
// tb_ring_4_monitor
// ----------------------------------------------------------------------------
// Self-checking bench for ring_4_monitor (WIDTH=4, rotate left, LOCK_CNT=2,
// REV_W=8, ERR_W=2). Every sample drives the DUT and pushes the expected
// register state, computed from a behavioural reference of the monitor, onto
// a scoreboard queue; a monitor process pops and compares one entry after the
// clock edge that consumes the sample. Each scenario task also checks the
// key observable facts of its scenario directly against constants.
// ============================================================================
module tb_ring_4_monitor;

    localparam int CLK_HALF = 5;

    typedef struct packed {
        logic [1:0] phase;
        logic       pv;
        logic       locked;
        logic       wrap;
        logic [7:0] rev;
        logic       err;
        logic [1:0] errc;
    } exp_t;

    typedef enum int {M_ACQ, M_LOCK, M_FAULT} mst_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic       clear;
    logic [3:0] q;
    logic [1:0] phase;
    logic       phase_valid;
    logic       locked;
    logic       wrap;
    logic [7:0] rev_count;
    logic       err;
    logic [1:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb_q[$];
    exp_t sb_e;

    // Reference model state
    exp_t       m_out;
    mst_t       m_st;
    int         m_good;
    logic [3:0] m_prev;
    logic       m_have_prev;

`ifdef RING_MON_ERRCNT_EN
    localparam logic [1:0] ERRC_SAT = 2'd3;
`else
    localparam logic [1:0] ERRC_SAT = 2'd0;
`endif

    ring_4_monitor #(
        .WIDTH    (4),
        .ROT_LEFT (1),
        .LOCK_CNT (2),
        .REV_W    (8),
        .ERR_W    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .clear       (clear),
        .q           (q),
        .phase       (phase),
        .phase_valid (phase_valid),
        .locked      (locked),
        .wrap        (wrap),
        .rev_count   (rev_count),
        .err         (err),
        .err_count   (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #CLK_HALF clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    task automatic model_reset();
        m_out       = '0;
        m_st        = M_ACQ;
        m_good      = 0;
        m_prev      = '0;
        m_have_prev = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_step(input logic [3:0] qv, input logic env, input logic clr);
        logic oh;
        logic legal;
        if (env) begin
            oh    = ($countones(qv) == 1);
            legal = oh && m_have_prev && (qv == {m_prev[2:0], m_prev[3]});
            m_out.wrap = 1'b0;
            case (m_st)
                M_ACQ: begin
                    if (legal) begin
                        m_good++;
                        if (m_good == 2) begin
                            m_st   = M_LOCK;
                            m_good = 0;
                        end
                    end else begin
                        m_good = 0;
                    end
                end
                M_LOCK: begin
                    if (legal) begin
                        if (qv == 4'b0001) begin
                            m_out.wrap = 1'b1;
                            m_out.rev  = m_out.rev + 8'd1;
                        end
                    end else begin
                        m_st      = M_FAULT;
                        m_out.err = 1'b1;
                        if (m_out.errc != ERRC_SAT) m_out.errc = m_out.errc + 2'd1;
                    end
                end
                default: begin
                    if (oh) begin
                        m_st   = M_ACQ;
                        m_good = 0;
                    end
                end
            endcase
            m_prev      = qv;
            m_have_prev = 1'b1;
            if (oh) begin
                for (int i = 0; i < 4; i++) if (qv[i]) m_out.phase = i[1:0];
            end
            m_out.pv     = oh;
            m_out.locked = (m_st == M_LOCK);
        end else begin
            m_out.wrap = 1'b0;
        end
        if (clr) begin
            m_out.rev  = '0;
            m_out.err  = 1'b0;
            m_out.errc = '0;
        end
    endtask

    // One sample: drive at the falling edge, push the expectation, return
    // shortly after the rising edge that consumed it (outputs settled).
    task automatic sample(input logic [3:0] qv, input logic env = 1'b1,
                          input logic clr = 1'b0);
        @(negedge clk);
        q     = qv;
        en    = env;
        clear = clr;
        model_step(qv, env, clr);
        sb_q.push_back(m_out);
        @(posedge clk);
        #2;
        en    = 1'b0;
        clear = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Scoreboard monitor
    // ------------------------------------------------------------------------
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            n_checks++;
            if ({phase, phase_valid, locked, wrap, rev_count, err, err_count} !== sb_e) begin
                n_errors++;
                $display("FAIL scoreboard t=%0t: got ph=%0d pv=%0b lk=%0b wr=%0b rev=%0d err=%0b ec=%0d, exp ph=%0d pv=%0b lk=%0b wr=%0b rev=%0d err=%0b ec=%0d",
                         $time, phase, phase_valid, locked, wrap, rev_count, err, err_count,
                         sb_e.phase, sb_e.pv, sb_e.locked, sb_e.wrap, sb_e.rev, sb_e.err, sb_e.errc);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        en    = 1'b0;
        clear = 1'b0;
        q     = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({phase, phase_valid, locked, wrap, rev_count, err, err_count} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h, exp 0",
                     {phase, phase_valid, locked, wrap, rev_count, err, err_count});
        end
        reset = 1'b1;
    endtask

    task automatic test_rotation();
        logic [3:0] v;
        v = 4'b0001;
        for (int s = 1; s <= 13; s++) begin
            sample(v);
            n_checks++;
            if (locked !== (s >= 3)) begin
                n_errors++;
                $display("FAIL rot_locked s=%0d: got %0b exp %0b", s, locked, (s >= 3));
            end
            n_checks++;
            if (wrap !== (s == 5 || s == 9 || s == 13)) begin
                n_errors++;
                $display("FAIL rot_wrap s=%0d: got %0b exp %0b", s, wrap,
                         (s == 5 || s == 9 || s == 13));
            end
            v = {v[2:0], v[3]};
        end
        n_checks++;
        if (rev_count !== 8'd3 || err !== 1'b0 || phase !== 2'd0) begin
            n_errors++;
            $display("FAIL rot_final: got rev=%0d err=%0b ph=%0d, exp rev=3 err=0 ph=0",
                     rev_count, err, phase);
        end
    endtask

    task automatic test_dup_fault();
        // Locked at 0001 from the rotation test.
        sample(4'b0011);
        n_checks++;
        if (err !== 1'b1 || err_count !== (ERRC_SAT == 0 ? 2'd0 : 2'd1) ||
            locked !== 1'b0 || phase_valid !== 1'b0 || phase !== 2'd0) begin
            n_errors++;
            $display("FAIL dup_fault: got err=%0b ec=%0d lk=%0b pv=%0b ph=%0d, exp 1 %0d 0 0 0",
                     err, err_count, locked, phase_valid, phase, (ERRC_SAT == 0 ? 0 : 1));
        end
        sample(4'b0100);
        sample(4'b1000);
        n_checks++;
        if (locked !== 1'b0) begin
            n_errors++;
            $display("FAIL dup_relock_early: got locked=%0b exp 0", locked);
        end
        sample(4'b0001);
        n_checks++;
        if (locked !== 1'b1 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL dup_relock: got locked=%0b err=%0b exp 1 1", locked, err);
        end
    endtask

    task automatic test_skip_fault();
        sample(4'b0010);
        sample(4'b1000);
        n_checks++;
        if (locked !== 1'b0 || err !== 1'b1 || phase !== 2'd3 || phase_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL skip_fault: got lk=%0b err=%0b ph=%0d pv=%0b exp 0 1 3 1",
                     locked, err, phase, phase_valid);
        end
    endtask

    task automatic test_clear_fault();
        sample(4'b0001);
        sample(4'b0010);
        sample(4'b0100);
        n_checks++;
        if (locked !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_prelock: got locked=%0b exp 1", locked);
        end
        sample(4'b0000, 1'b1, 1'b1);
        n_checks++;
        if (err !== 1'b0 || err_count !== 2'd0 || locked !== 1'b0 || rev_count !== 8'd0) begin
            n_errors++;
            $display("FAIL clear_fault: got err=%0b ec=%0d lk=%0b rev=%0d exp 0 0 0 0",
                     err, err_count, locked, rev_count);
        end
    endtask

    task automatic test_async_reset();
        sample(4'b0001);
        sample(4'b0010);
        sample(4'b0100);
        for (int r = 0; r < 5; r++) begin
            sample(4'b1000);
            sample(4'b0001);
            sample(4'b0010);
            sample(4'b0100);
        end
        n_checks++;
        if (rev_count !== 8'd5 || locked !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_pre: got rev=%0d lk=%0b exp 5 1", rev_count, locked);
        end
        // Still in the high phase, well before the next rising edge.
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({phase, phase_valid, locked, wrap, rev_count, err, err_count} !== '0) begin
            n_errors++;
            $display("FAIL areset_immediate: got %h exp 0",
                     {phase, phase_valid, locked, wrap, rev_count, err, err_count});
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_rev_rollover();
        sample(4'b0001);
        sample(4'b0010);
        sample(4'b0100);
        for (int r = 1; r <= 256; r++) begin
            sample(4'b1000);
            sample(4'b0001);
            if (r == 255) begin
                n_checks++;
                if (rev_count !== 8'd255 || wrap !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rev_max: got rev=%0d wrap=%0b exp 255 1", rev_count, wrap);
                end
            end
            sample(4'b0010);
            sample(4'b0100);
        end
        n_checks++;
        if (rev_count !== 8'd0 || locked !== 1'b1) begin
            n_errors++;
            $display("FAIL rev_rollover: got rev=%0d lk=%0b exp 0 1", rev_count, locked);
        end
    endtask

    task automatic test_err_saturate();
        // Currently locked at 0100: fault it with clear to start from zero.
        sample(4'b0000, 1'b1, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            sample(4'b0001);
            sample(4'b0010);
            sample(4'b0100);
            n_checks++;
            if (locked !== 1'b1) begin
                n_errors++;
                $display("FAIL sat_lock c=%0d: got locked=%0b exp 1", c, locked);
            end
            sample(4'b0000);
        end
        n_checks++;
        if (err_count !== ERRC_SAT || err !== 1'b1 || locked !== 1'b0) begin
            n_errors++;
            $display("FAIL err_saturate: got ec=%0d err=%0b lk=%0b exp %0d 1 0",
                     err_count, err, locked, ERRC_SAT);
        end
    endtask

    task automatic test_enable_hold();
        logic [15:0] snap;
        snap = {phase, phase_valid, locked, wrap, rev_count, err, err_count};
        for (int c = 0; c < 10; c++) begin
            sample(4'($urandom_range(0, 15)), 1'b0, 1'b0);
            n_checks++;
            if ({phase, phase_valid, locked, wrap, rev_count, err, err_count} !== snap) begin
                n_errors++;
                $display("FAIL en_hold c=%0d: got %h exp %h", c,
                         {phase, phase_valid, locked, wrap, rev_count, err, err_count}, snap);
            end
        end
        // clear acts with en low.
        sample(4'b0010, 1'b0, 1'b1);
        n_checks++;
        if (err !== 1'b0 || err_count !== 2'd0 || rev_count !== 8'd0 || phase_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_no_en: got err=%0b ec=%0d rev=%0d pv=%0b exp 0 0 0 0",
                     err, err_count, rev_count, phase_valid);
        end
        sample(4'b0100);
        n_checks++;
        if (phase !== 2'd2 || phase_valid !== 1'b1 || locked !== 1'b0) begin
            n_errors++;
            $display("FAIL en_resume: got ph=%0d pv=%0b lk=%0b exp 2 1 0",
                     phase, phase_valid, locked);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_dup_fault();
        test_skip_fault();
        test_clear_fault();
        test_async_reset();
        test_rev_rollover();
        test_err_saturate();
        test_enable_hold();
        repeat (2) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_drain: %0d entries left", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
